gate_test_sequencer: RTL and testbench

Synthesizable stimulus-and-check stage placed directly upstream of, and wrapped around, the lab combinational gate under test (3-input XNOR by default). It walks all 2^N_INPUTS input combinations in ascending binary order and holds each one for a programmable number of cycles. On the last hold cycle of each vector it samples the gate output and compares it against the expected XNOR. It reports pass/fail, a mismatch count and the first failing vector, which replaces hand-written per-vector delay stimulus.

---
 rtl/gate_test_sequencer.sv | 163 ++++++++++++++++
 tb/tb_gate_test_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_test_sequencer.sv
// Exhaustive stimulus/check sequencer for a combinational gate under test.
// Walks every input vector in ascending order, holds each one, samples the gate on the last hold cycle and scores it.
module gate_test_sequencer #(
    parameter int N_INPUTS    = 3,
    parameter int HOLD_CYCLES = 50,
    parameter int ERR_W       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    output logic [N_INPUTS-1:0] vec_out,
    input  logic                x_in,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_count,
    output logic [N_INPUTS-1:0] first_err_vec
);

    localparam int                HC_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Reference behaviour of the gate: XNOR of all inputs.
    function automatic logic expected_fn(input logic [N_INPUTS-1:0] v);
        return ~^v;
    endfunction

    state_e                state_q, state_d;
    logic [HC_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic [N_INPUTS-1:0]   vec_out_q, vec_out_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [ERR_W-1:0]      err_count_q, err_count_d;
    logic [N_INPUTS-1:0]   first_err_vec_q, first_err_vec_d;

    logic                  mism_s;
    logic                  sample_s;
    logic                  last_vec_s;

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d         = state_q;
        hold_cnt_d      = hold_cnt_q;
        vec_out_d       = vec_out_q;
        busy_d          = busy_q;
        done_d          = done_q;
        pass_d          = pass_q;
        err_count_d     = err_count_q;
        first_err_vec_d = first_err_vec_q;

        mism_s     = (x_in != expected_fn(vec_out_q));
        sample_s   = (hold_cnt_q == HOLD_LAST);
        last_vec_s = &vec_out_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d         = ST_HOLD;
                    hold_cnt_d      = {HC_W{1'b0}};
                    vec_out_d       = {N_INPUTS{1'b0}};
                    busy_d          = 1'b1;
                    done_d          = 1'b0;
                    pass_d          = 1'b0;
                    err_count_d     = {ERR_W{1'b0}};
                    first_err_vec_d = {N_INPUTS{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end

            ST_HOLD: begin
                // abort outranks a coincident sample edge
                if (abort) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = {HC_W{1'b0}};
                    vec_out_d  = {N_INPUTS{1'b0}};
                    busy_d     = 1'b0;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                end else if (sample_s) begin
                    if (mism_s) begin
                        if (err_count_q != ERR_MAX) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end else begin
                            err_count_d = err_count_q;
                        end
                        if (err_count_q == {ERR_W{1'b0}}) begin
                            first_err_vec_d = vec_out_q;
                        end else begin
                            first_err_vec_d = first_err_vec_q;
                        end
                    end else begin
                        err_count_d = err_count_q;
                    end

                    if (last_vec_s) begin
                        state_d    = ST_DONE;
                        hold_cnt_d = {HC_W{1'b0}};
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        pass_d     = (err_count_q == {ERR_W{1'b0}}) && !mism_s;
                    end else begin
                        vec_out_d  = vec_out_q + N_INPUTS'(1);
                        hold_cnt_d = {HC_W{1'b0}};
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end

            default: begin
                state_d         = ST_IDLE;
                hold_cnt_d      = {HC_W{1'b0}};
                vec_out_d       = {N_INPUTS{1'b0}};
                busy_d          = 1'b0;
                done_d          = 1'b0;
                pass_d          = 1'b0;
                err_count_d     = {ERR_W{1'b0}};
                first_err_vec_d = {N_INPUTS{1'b0}};
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            hold_cnt_q      <= {HC_W{1'b0}};
            vec_out_q       <= {N_INPUTS{1'b0}};
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            err_count_q     <= {ERR_W{1'b0}};
            first_err_vec_q <= {N_INPUTS{1'b0}};
        end else begin
            state_q         <= state_d;
            hold_cnt_q      <= hold_cnt_d;
            vec_out_q       <= vec_out_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
            err_count_q     <= err_count_d;
            first_err_vec_q <= first_err_vec_d;
        end
    end

    assign vec_out       = vec_out_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_count_q;
    assign first_err_vec = first_err_vec_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Randomized self-checking bench: two sequencer instances (hold 4 / err width 2, hold 1 / err width 4)
// compared every cycle against a run-time based behavioural model, plus hand-computed expectations.
module tb_gate_test_sequencer;

    localparam int NV = 8;

    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic       rnd0, rnd1;
    int         mode;

    logic [2:0] vec0, vec1, fev0, fev1;
    logic       x0, x1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [1:0] err0;
    logic [3:0] err1;

    int n_checks = 0;
    int n_err    = 0;

    // model state, indexed by instance
    int h[2]    = '{4, 1};
    int emax[2] = '{3, 15};
    bit m_run[2];
    int m_t[2], m_vec[2], m_err[2], m_fev[2];
    bit m_pass[2], m_done[2];

    // gate under test: 0 good, 1 stuck-at-0, 2 inverted, 3 random
    function automatic logic gate_fn(input int md, input logic [2:0] v, input logic r);
        case (md)
            0:       return ~^v;
            1:       return 1'b0;
            2:       return ^v;
            default: return r;
        endcase
    endfunction

    assign x0 = gate_fn(mode, vec0, rnd0);
    assign x1 = gate_fn(mode, vec1, rnd1);

    always #5 clk = ~clk;

    gate_test_sequencer #(.N_INPUTS(3), .HOLD_CYCLES(4), .ERR_W(2)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec_out(vec0), .x_in(x0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_err_vec(fev0));

    gate_test_sequencer #(.N_INPUTS(3), .HOLD_CYCLES(1), .ERR_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec_out(vec1), .x_in(x1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_err_vec(fev1));

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 1'b0; m_t[k] = 0; m_vec[k] = 0; m_err[k] = 0;
            m_fev[k] = 0; m_pass[k] = 1'b0; m_done[k] = 1'b0;
        end
    endtask

    // Advance the model by one clock edge using the inputs present before that edge.
    task automatic model_update();
        logic xs[2];
        int   v;
        bit   ex, mism;
        xs[0] = x0;
        xs[1] = x1;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (m_run[k]) begin
                if (abort) begin
                    m_run[k] = 1'b0; m_vec[k] = 0; m_done[k] = 1'b0; m_pass[k] = 1'b0;
                end else begin
                    v = m_t[k] / h[k];
                    if (m_t[k] % h[k] == h[k] - 1) begin
                        ex   = (((v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1)) % 2) == 0;
                        mism = (xs[k] != ex);
                        if (mism) begin
                            if (m_err[k] == 0) m_fev[k] = v;
                            if (m_err[k] < emax[k]) m_err[k]++;
                        end
                        if (v == NV - 1) begin
                            m_run[k]  = 1'b0;
                            m_done[k] = 1'b1;
                            m_pass[k] = (m_err[k] == 0);
                        end
                    end
                    m_t[k]++;
                    if (m_run[k]) m_vec[k] = m_t[k] / h[k];
                end
            end else if (start) begin
                m_run[k] = 1'b1; m_t[k] = 0; m_vec[k] = 0; m_err[k] = 0;
                m_fev[k] = 0; m_pass[k] = 1'b0; m_done[k] = 1'b0;
            end
        end
    endtask

    // one clock: entered and left just after a falling edge
    task automatic step();
        rnd0 = 1'($urandom_range(0, 1));
        rnd1 = 1'($urandom_range(0, 1));
        #1;
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_until_done(input int inst, output int n);
        n = 0;
        while (!((inst == 0) ? done0 : done1) && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) begin
            n_checks++;
            n_err++;
            $display("FAIL done_timeout inst=%0d waited=%0d cycles", inst, n);
        end
    endtask

    task automatic run_until_vec0(input int target);
        int n = 0;
        while (int'(vec0) != target && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_err++;
            $display("FAIL vec_timeout got=%0d expected=%0d", vec0, target);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Every-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("i0_vec",  int'(vec0),  m_vec[0]);
            chk("i0_busy", int'(busy0), int'(m_run[0]));
            chk("i0_done", int'(done0), int'(m_done[0]));
            chk("i0_pass", int'(pass0), int'(m_pass[0]));
            chk("i0_err",  int'(err0),  m_err[0]);
            chk("i0_fev",  int'(fev0),  m_fev[0]);
            chk("i1_vec",  int'(vec1),  m_vec[1]);
            chk("i1_busy", int'(busy1), int'(m_run[1]));
            chk("i1_done", int'(done1), int'(m_done[1]));
            chk("i1_pass", int'(pass1), int'(m_pass[1]));
            chk("i1_err",  int'(err1),  m_err[1]);
            chk("i1_fev",  int'(fev1),  m_fev[1]);
        end
    end

    initial begin
        int n, n1;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 0; rnd0 = 1'b0; rnd1 = 1'b0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("reset_vec0",  int'(vec0),  0);
        chk("reset_busy0", int'(busy0), 0);
        chk("reset_done1", int'(done1), 0);

        // good gate: done 32 edges (hold 4) and 8 edges (hold 1) after the accepting edge
        mode = 0;
        pulse_start();
        n = 0; n1 = -1;
        while (!done0 && n < 400) begin
            step();
            n++;
            if (done1 && n1 < 0) n1 = n;
        end
        chk("good_done_edges_i0", n, 32);
        chk("good_done_edges_i1", n1, 8);
        chk("good_pass_i0", int'(pass0), 1);
        chk("good_err_i0",  int'(err0),  0);
        chk("good_vec_i0",  int'(vec0),  7);

        // stuck-at-0: mismatches on vectors 0,3,5,6
        mode = 1;
        pulse_start();
        run_until_done(0, n);
        chk("stuck0_err_i1",  int'(err1),  4);
        chk("stuck0_err_i0",  int'(err0),  3);
        chk("stuck0_fev_i1",  int'(fev1),  0);
        chk("stuck0_pass_i0", int'(pass0), 0);

        // inverted gate: every vector mismatches
        mode = 2;
        pulse_start();
        run_until_done(0, n);
        chk("inv_err_sat_i0", int'(err0), 3);
        chk("inv_err_i1",     int'(err1), 8);
        chk("inv_pass_i1",    int'(pass1), 0);

        // start while running is ignored
        mode = 0;
        pulse_start();
        run_until_vec0(2);
        pulse_start();
        run_until_done(0, n);
        chk("restart_ignored_pass_i0", int'(pass0), 1);

        // abort at vector 3 keeps partial error count
        mode = 1;
        pulse_start();
        run_until_vec0(3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_vec_i0",  int'(vec0),  0);
        chk("abort_busy_i0", int'(busy0), 0);
        chk("abort_err_i0",  int'(err0),  1);
        chk("abort_done_unaffected_i1", int'(done1), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        chk("abort_idle_noeffect_i0", int'(busy0), 0);

        // asynchronous reset in the middle of a cycle
        mode = 0;
        pulse_start();
        run_until_vec0(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_vec_i0",  int'(vec0),  0);
        chk("async_rst_busy_i0", int'(busy0), 0);
        chk("async_rst_err_i1",  int'(err1),  0);
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        pulse_start();
        run_until_done(0, n);
        chk("after_rst_pass_i0", int'(pass0), 1);

        // hold 1: start held (with abort) in DONE restarts; faulty second run fails
        pulse_start();
        run_until_done(1, n);
        chk("h1_pass_i1", int'(pass1), 1);
        mode = 1;
        start = 1'b1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("h1_restart_vec_i1",  int'(vec1),  0);
        chk("h1_restart_busy_i1", int'(busy1), 1);
        chk("h1_restart_err_i1",  int'(err1),  0);
        run_until_done(1, n);
        start = 1'b0;
        chk("h1_faulty_pass_i1", int'(pass1), 0);
        chk("h1_faulty_err_i1",  int'(err1),  4);
        step();

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 15) == 0);
            abort = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 99) == 0) mode = $urandom_range(0, 3);
            step();
        end
        start = 1'b0;
        abort = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
